// File: rtl/can_brs_pkg.sv
// Shared types for the CAN FD bit-rate-switch controller: FSM states, timing
// register layouts, reset defaults and cfg_wdata field offsets.
package can_brs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_FAST = 2'd2,
    ST_TAIL = 2'd3
  } brs_state_t;

  typedef struct packed {
    logic       ts;
    logic [4:0] sjw;
    logic [6:0] brp;
    logic [5:0] ps2;
    logic [5:0] ps1;
    logic [6:0] prop;
  } nom_timing_t;

  typedef struct packed {
    logic       ts;
    logic [4:0] sjw;
    logic [6:0] brp;
    logic [4:0] ps2;
    logic [4:0] ps1;
    logic [5:0] prop;
  } fd_timing_t;

  localparam nom_timing_t NOM_DEFAULT = '{
    ts: 1'b0, sjw: 5'd0, brp: 7'd0, ps2: 6'd2, ps1: 6'd3, prop: 7'd1
  };

  localparam fd_timing_t FD_DEFAULT = '{
    ts: 1'b0, sjw: 5'd0, brp: 7'd0, ps2: 5'd1, ps1: 5'd2, prop: 6'd1
  };

  // Nominal word layout, LSB first.
  localparam int NOM_PROP_LSB = 0;
  localparam int NOM_PS1_LSB  = 7;
  localparam int NOM_PS2_LSB  = 13;
  localparam int NOM_BRP_LSB  = 19;
  localparam int NOM_SJW_LSB  = 26;
  localparam int NOM_TS_BIT   = 31;

  // FD word layout, LSB first; bits [31:29] are don't-care.
  localparam int FD_PROP_LSB = 0;
  localparam int FD_PS1_LSB  = 6;
  localparam int FD_PS2_LSB  = 11;
  localparam int FD_BRP_LSB  = 16;
  localparam int FD_SJW_LSB  = 23;
  localparam int FD_TS_BIT   = 28;

  localparam int WDOG_W = 10;

  function automatic nom_timing_t unpack_nom(input logic [31:0] w);
    nom_timing_t t;
    t.prop = w[NOM_PROP_LSB +: 7];
    t.ps1  = w[NOM_PS1_LSB +: 6];
    t.ps2  = w[NOM_PS2_LSB +: 6];
    t.brp  = w[NOM_BRP_LSB +: 7];
    t.sjw  = w[NOM_SJW_LSB +: 5];
    t.ts   = w[NOM_TS_BIT];
    return t;
  endfunction

  function automatic fd_timing_t unpack_fd(input logic [31:0] w);
    fd_timing_t t;
    t.prop = w[FD_PROP_LSB +: 6];
    t.ps1  = w[FD_PS1_LSB +: 5];
    t.ps2  = w[FD_PS2_LSB +: 5];
    t.brp  = w[FD_BRP_LSB +: 7];
    t.sjw  = w[FD_SJW_LSB +: 5];
    t.ts   = w[FD_TS_BIT];
    return t;
  endfunction

endpackage

// File: rtl/can_brs_cfg_regs.sv
// Nominal/FD bit-timing register bank. With CAN_BRS_SHADOW_EN defined, writes
// outside IDLE land in a shadow copy and are applied on the next IDLE cycle.
module can_brs_cfg_regs
  import can_brs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_idle,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [31:0] cfg_wdata,
  output nom_timing_t nom_active,
  output fd_timing_t  fd_active,
  output logic        cfg_pending
);

  nom_timing_t nom_wr;
  fd_timing_t  fd_wr;
  logic        nom_we;
  logic        fd_we;

  assign nom_wr = unpack_nom(cfg_wdata);
  assign fd_wr  = unpack_fd(cfg_wdata);
  assign nom_we = cfg_we & ~cfg_sel;
  assign fd_we  = cfg_we & cfg_sel;

  nom_timing_t nom_active_reg;
  fd_timing_t  fd_active_reg;

`ifdef CAN_BRS_SHADOW_EN
  nom_timing_t nom_shadow_reg;
  fd_timing_t  fd_shadow_reg;
  logic        nom_pend_reg;
  logic        fd_pend_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      nom_shadow_reg <= NOM_DEFAULT;
      fd_shadow_reg  <= FD_DEFAULT;
      nom_active_reg <= NOM_DEFAULT;
      fd_active_reg  <= FD_DEFAULT;
      nom_pend_reg   <= 1'b0;
      fd_pend_reg    <= 1'b0;
    end else begin
      if (nom_we) nom_shadow_reg <= nom_wr;
      if (fd_we)  fd_shadow_reg  <= fd_wr;
      if (in_idle) begin
        // A direct write in the apply cycle beats the pending shadow value.
        if (nom_we)            nom_active_reg <= nom_wr;
        else if (nom_pend_reg) nom_active_reg <= nom_shadow_reg;
        if (fd_we)             fd_active_reg  <= fd_wr;
        else if (fd_pend_reg)  fd_active_reg  <= fd_shadow_reg;
        nom_pend_reg <= 1'b0;
        fd_pend_reg  <= 1'b0;
      end else begin
        if (nom_we) nom_pend_reg <= 1'b1;
        if (fd_we)  fd_pend_reg  <= 1'b1;
      end
    end
  end

  assign cfg_pending = nom_pend_reg | fd_pend_reg;
`else
  logic unused_in_idle;
  assign unused_in_idle = in_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      nom_active_reg <= NOM_DEFAULT;
      fd_active_reg  <= FD_DEFAULT;
    end else begin
      if (nom_we) nom_active_reg <= nom_wr;
      if (fd_we)  fd_active_reg  <= fd_wr;
    end
  end

  assign cfg_pending = 1'b0;
`endif

  assign nom_active = nom_active_reg;
  assign fd_active  = fd_active_reg;

endmodule

// File: rtl/can_brs_ctrl.sv
// CAN FD bit-rate-switch controller: frame-phase FSM, fast-phase watchdog and
// timing register bank. Define CAN_BRS_SHADOW_EN for shadowed config writes.
module can_brs_ctrl
  import can_brs_pkg::*;
#(
  parameter int MAX_FAST_BITS = 700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_FD_rx,
  input  logic        sample_point,
  input  logic        sampled_bit,
  input  logic        rx_idle,
  input  logic        rx_inter,
  input  logic        fdf_detected,
  input  logic        brs_sp,
  input  logic        crc_delim_sp,
  input  logic        go_error_frame,
  input  logic        go_overload_frame,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [31:0] cfg_wdata,
  output logic        go_rx_brs_on,
  output logic        fdf_brs_r_on,
  output logic [6:0]  prop_seg,
  output logic [5:0]  phase_seg_1,
  output logic [5:0]  phase_seg_2,
  output logic [6:0]  baud_r_presc,
  output logic [4:0]  sjw,
  output logic        triple_sampling,
  output logic [5:0]  prop_seg_fd,
  output logic [4:0]  phase_seg_1_fd,
  output logic [4:0]  phase_seg_2_fd,
  output logic [6:0]  baud_r_presc_fd,
  output logic [4:0]  sjw_fd,
  output logic        triple_sampling_fd,
  output logic        cfg_pending,
  output logic        fast_wdog_err
);

  // The watchdog counter is WDOG_W bits wide, so MAX_FAST_BITS must fit in it.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MAX_FAST_BITS - 1);

  brs_state_t        state_reg;
  logic              fdf_seen_reg;
  logic              fdf_brs_r_on_reg;
  logic              fast_wdog_err_reg;
  logic [WDOG_W-1:0] wdog_cnt_reg;

  logic brs_switch;
  logic frame_end;
  logic wdog_expire;
  logic fast_exit;

  assign frame_end   = (rx_idle | rx_inter) & sample_point;
  assign brs_switch  = (state_reg == ST_ARB) & brs_sp & sampled_bit & fdf_seen_reg
                     & en_FD_rx & ~go_error_frame;
  assign wdog_expire = (state_reg == ST_FAST) & sample_point & (wdog_cnt_reg == WDOG_LAST);
  assign fast_exit   = crc_delim_sp | go_error_frame | go_overload_frame | ~en_FD_rx
                     | wdog_expire;

  assign go_rx_brs_on = brs_switch & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      fdf_seen_reg      <= 1'b0;
      fdf_brs_r_on_reg  <= 1'b0;
      fast_wdog_err_reg <= 1'b0;
      wdog_cnt_reg      <= '0;
    end else begin
      fast_wdog_err_reg <= wdog_expire;
      case (state_reg)
        ST_IDLE: begin
          if (sample_point & ~sampled_bit) state_reg <= ST_ARB;
        end
        ST_ARB: begin
          if (fdf_detected) fdf_seen_reg <= 1'b1;
          if (go_error_frame) begin
            state_reg <= ST_ARB;
          end else if (brs_switch) begin
            state_reg        <= ST_FAST;
            fdf_brs_r_on_reg <= 1'b1;
            wdog_cnt_reg     <= '0;
          end else if (frame_end) begin
            state_reg    <= ST_IDLE;
            fdf_seen_reg <= 1'b0;
          end
        end
        ST_FAST: begin
          if (fast_exit) begin
            state_reg        <= ST_TAIL;
            fdf_brs_r_on_reg <= 1'b0;
          end else if (sample_point) begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
          end
        end
        ST_TAIL: begin
          if (frame_end) begin
            state_reg    <= ST_IDLE;
            fdf_seen_reg <= 1'b0;
          end
        end
        default: begin
          state_reg        <= ST_IDLE;
          fdf_seen_reg     <= 1'b0;
          fdf_brs_r_on_reg <= 1'b0;
        end
      endcase
    end
  end

  assign fdf_brs_r_on  = fdf_brs_r_on_reg;
  assign fast_wdog_err = fast_wdog_err_reg;

  nom_timing_t nom_active;
  fd_timing_t  fd_active;

  can_brs_cfg_regs u_cfg_regs (
    .clk         (clk),
    .rst         (rst),
    .in_idle     (state_reg == ST_IDLE),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_wdata   (cfg_wdata),
    .nom_active  (nom_active),
    .fd_active   (fd_active),
    .cfg_pending (cfg_pending)
  );

  assign prop_seg           = nom_active.prop;
  assign phase_seg_1        = nom_active.ps1;
  assign phase_seg_2        = nom_active.ps2;
  assign baud_r_presc       = nom_active.brp;
  assign sjw                = nom_active.sjw;
  assign triple_sampling    = nom_active.ts;
  assign prop_seg_fd        = fd_active.prop;
  assign phase_seg_1_fd     = fd_active.ps1;
  assign phase_seg_2_fd     = fd_active.ps2;
  assign baud_r_presc_fd    = fd_active.brp;
  assign sjw_fd             = fd_active.sjw;
  assign triple_sampling_fd = fd_active.ts;

endmodule

// File: tb/tb_can_brs_ctrl.sv
// Scoreboard bench for can_brs_ctrl (MAX_FAST_BITS=8): stimulus queues expected
// levels and pulses by cycle; a negedge monitor pops and compares them.
module tb_can_brs_ctrl;

`ifdef CAN_BRS_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  localparam int S_FAST = 0, S_WDOG = 1, S_PEND = 2, S_PROP = 3, S_PS1 = 4, S_PS2 = 5,
                 S_BRP = 6, S_SJW = 7, S_TS = 8, S_PROP_FD = 9, S_PS1_FD = 10,
                 S_PS2_FD = 11, S_BRP_FD = 12, S_SJW_FD = 13, S_TS_FD = 14;
  localparam int K_BRS = 0, K_WDOG = 1;

  logic        clk = 1'b0;
  logic        rst, en_FD_rx, sample_point, sampled_bit, rx_idle, rx_inter;
  logic        fdf_detected, brs_sp, crc_delim_sp, go_error_frame, go_overload_frame;
  logic        cfg_we, cfg_sel;
  logic [31:0] cfg_wdata;
  logic        go_rx_brs_on, fdf_brs_r_on, triple_sampling, triple_sampling_fd;
  logic        cfg_pending, fast_wdog_err;
  logic [6:0]  prop_seg, baud_r_presc, baud_r_presc_fd;
  logic [5:0]  phase_seg_1, phase_seg_2, prop_seg_fd;
  logic [4:0]  sjw, phase_seg_1_fd, phase_seg_2_fd, sjw_fd;

  can_brs_ctrl #(.MAX_FAST_BITS(8)) dut (
    .clk(clk), .rst(rst), .en_FD_rx(en_FD_rx), .sample_point(sample_point),
    .sampled_bit(sampled_bit), .rx_idle(rx_idle), .rx_inter(rx_inter),
    .fdf_detected(fdf_detected), .brs_sp(brs_sp), .crc_delim_sp(crc_delim_sp),
    .go_error_frame(go_error_frame), .go_overload_frame(go_overload_frame),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .go_rx_brs_on(go_rx_brs_on), .fdf_brs_r_on(fdf_brs_r_on),
    .prop_seg(prop_seg), .phase_seg_1(phase_seg_1), .phase_seg_2(phase_seg_2),
    .baud_r_presc(baud_r_presc), .sjw(sjw), .triple_sampling(triple_sampling),
    .prop_seg_fd(prop_seg_fd), .phase_seg_1_fd(phase_seg_1_fd),
    .phase_seg_2_fd(phase_seg_2_fd), .baud_r_presc_fd(baud_r_presc_fd),
    .sjw_fd(sjw_fd), .triple_sampling_fd(triple_sampling_fd),
    .cfg_pending(cfg_pending), .fast_wdog_err(fast_wdog_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } chk_t;

  typedef struct {
    int cyc;
    int kind;
  } pulse_t;

  chk_t   chk_q[$];
  pulse_t pulse_q[$];
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  bit     mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(input int sig);
    case (sig)
      S_FAST:    return 32'(fdf_brs_r_on);
      S_WDOG:    return 32'(fast_wdog_err);
      S_PEND:    return 32'(cfg_pending);
      S_PROP:    return 32'(prop_seg);
      S_PS1:     return 32'(phase_seg_1);
      S_PS2:     return 32'(phase_seg_2);
      S_BRP:     return 32'(baud_r_presc);
      S_SJW:     return 32'(sjw);
      S_TS:      return 32'(triple_sampling);
      S_PROP_FD: return 32'(prop_seg_fd);
      S_PS1_FD:  return 32'(phase_seg_1_fd);
      S_PS2_FD:  return 32'(phase_seg_2_fd);
      S_BRP_FD:  return 32'(baud_r_presc_fd);
      S_SJW_FD:  return 32'(sjw_fd);
      S_TS_FD:   return 32'(triple_sampling_fd);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_pulse(input int kind, input logic act, input string name);
    int idx = -1;
    foreach (pulse_q[i]) if (pulse_q[i].kind == kind && pulse_q[i].cyc == cyc) idx = i;
    if (idx >= 0) begin
      n_tests++;
      if (act !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL %s_pulse cyc=%0d actual=%b required=1", name, cyc, act);
      end else begin
        $display("[TB] ok   %s_pulse cyc=%0d", name, cyc);
      end
      pulse_q.delete(idx);
    end else if (act !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s_spurious cyc=%0d actual=%b required=0", name, cyc, act);
    end
  endtask

  // Monitor: compare every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = chk_q.size() - 1; i >= 0; i--) begin
        if (chk_q[i].cyc <= cyc) begin
          logic [31:0] act;
          act = get_sig(chk_q[i].sig);
          n_tests++;
          if (chk_q[i].cyc != cyc || act !== chk_q[i].val) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d actual=0x%0h required=0x%0h",
                     chk_q[i].name, cyc, act, chk_q[i].val);
          end else begin
            $display("[TB] ok   %s cyc=%0d value=0x%0h", chk_q[i].name, cyc, act);
          end
          chk_q.delete(i);
        end
      end
      check_pulse(K_BRS, go_rx_brs_on, "go_rx_brs_on");
      check_pulse(K_WDOG, fast_wdog_err, "fast_wdog_err");
    end
  end

  task automatic expect_val(input int delay, input int sig, input logic [31:0] val,
                            input string name);
    chk_t c;
    c.cyc = cyc + delay; c.sig = sig; c.val = val; c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic expect_pulse(input int delay, input int kind);
    pulse_t p;
    p.cyc = cyc + delay; p.kind = kind;
    pulse_q.push_back(p);
  endtask

  task automatic clear_inputs();
    rst = 1'b0; sample_point = 1'b0; sampled_bit = 1'b1; rx_idle = 1'b0;
    rx_inter = 1'b0; fdf_detected = 1'b0; brs_sp = 1'b0; crc_delim_sp = 1'b0;
    go_error_frame = 1'b0; go_overload_frame = 1'b0; cfg_we = 1'b0;
    cfg_sel = 1'b0; cfg_wdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic sof();
    sample_point = 1'b1; sampled_bit = 1'b0;
    tick();
  endtask

  task automatic enter_fast(input string tag);
    sof();
    fdf_detected = 1'b1;
    tick();
    brs_sp = 1'b1; sampled_bit = 1'b1; sample_point = 1'b1;
    expect_pulse(0, K_BRS);
    expect_val(0, S_FAST, 0, {tag, "_fast_at_strobe"});
    expect_val(1, S_FAST, 1, {tag, "_fast_after_strobe"});
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    en_FD_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_inputs();
    mon_en = 1'b1;

    // Reset state
    expect_val(0, S_FAST, 0, "rst_fast");
    expect_val(0, S_WDOG, 0, "rst_wdog");
    expect_val(0, S_PEND, 0, "rst_pending");
    expect_val(0, S_PROP, 1, "rst_prop");
    expect_val(0, S_PS1, 3, "rst_ps1");
    expect_val(0, S_PS2, 2, "rst_ps2");
    expect_val(0, S_BRP, 0, "rst_brp");
    expect_val(0, S_SJW, 0, "rst_sjw");
    expect_val(0, S_TS, 0, "rst_ts");
    expect_val(0, S_PROP_FD, 1, "rst_prop_fd");
    expect_val(0, S_PS1_FD, 2, "rst_ps1_fd");
    expect_val(0, S_PS2_FD, 1, "rst_ps2_fd");
    expect_val(0, S_BRP_FD, 0, "rst_brp_fd");
    tick();

    // FD frame: switch, a few fast bits, CRC delimiter ends the fast phase
    enter_fast("fd");
    repeat (3) begin sample_point = 1'b1; tick(); end
    crc_delim_sp = 1'b1;
    expect_val(0, S_FAST, 1, "fd_fast_before_crc");
    expect_val(1, S_FAST, 0, "fd_fast_after_crc");
    tick();
    rx_idle = 1'b1; sample_point = 1'b1;
    tick();

    // BRS sampled dominant: no switch, state stays ARB
    sof();
    fdf_detected = 1'b1;
    tick();
    brs_sp = 1'b1; sampled_bit = 1'b0; sample_point = 1'b1;
    expect_val(1, S_FAST, 0, "brs_dominant_no_fast");
    tick();
    brs_sp = 1'b1; sampled_bit = 1'b1;
    expect_pulse(0, K_BRS);
    expect_val(1, S_FAST, 1, "arb_kept_after_dominant");
    tick();
    go_error_frame = 1'b1;
    expect_val(1, S_FAST, 0, "err_exits_fast");
    tick();
    brs_sp = 1'b1; sampled_bit = 1'b1;
    expect_val(1, S_FAST, 0, "tail_ignores_brs");
    tick();
    rx_inter = 1'b1; sample_point = 1'b1;
    tick();
    brs_sp = 1'b1; sampled_bit = 1'b1;
    expect_val(1, S_FAST, 0, "idle_ignores_brs");
    tick();

    // No FDF seen, then an error frame in ARB blocks the strobe
    sof();
    brs_sp = 1'b1;
    expect_val(1, S_FAST, 0, "no_fdf_no_fast");
    tick();
    fdf_detected = 1'b1;
    tick();
    go_error_frame = 1'b1; brs_sp = 1'b1;
    expect_val(1, S_FAST, 0, "err_in_arb_blocks");
    tick();
    brs_sp = 1'b1;
    expect_pulse(0, K_BRS);
    expect_val(1, S_FAST, 1, "arb_kept_after_err");
    tick();

    // Config write during FAST (nominal brp=5, other fields at defaults)
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 32'h0028_4181;
    expect_val(1, S_BRP, SHADOW ? 32'd0 : 32'd5, "fast_write_brp");
    expect_val(1, S_PEND, SHADOW ? 32'd1 : 32'd0, "fast_write_pending");
    expect_val(1, S_PS1, 3, "fast_write_ps1");
    tick();

    // Watchdog: 8th sample point in FAST expires it
    for (int i = 1; i <= 8; i++) begin
      sample_point = 1'b1;
      if (i == 8) begin
        expect_pulse(1, K_WDOG);
        expect_val(1, S_FAST, 0, "wdog_fast_off");
      end else begin
        expect_val(1, S_FAST, 1, "wdog_fast_hold");
      end
      tick();
    end
    rx_idle = 1'b1; sample_point = 1'b1;
    expect_val(1, S_PEND, SHADOW ? 32'd1 : 32'd0, "idle_entry_pending");
    expect_val(1, S_BRP, SHADOW ? 32'd0 : 32'd5, "idle_entry_brp");
    tick();
    expect_val(1, S_BRP, 5, "applied_brp");
    expect_val(1, S_PEND, 0, "applied_pending");
    tick();

    // FD write in IDLE with junk in bits [31:29]
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_wdata = 32'hF082_19C5;
    expect_val(1, S_PROP_FD, 5, "fd_wr_prop");
    expect_val(1, S_PS1_FD, 7, "fd_wr_ps1");
    expect_val(1, S_PS2_FD, 3, "fd_wr_ps2");
    expect_val(1, S_BRP_FD, 2, "fd_wr_brp");
    expect_val(1, S_SJW_FD, 1, "fd_wr_sjw");
    expect_val(1, S_TS_FD, 1, "fd_wr_ts");
    expect_val(1, S_BRP, 5, "fd_wr_nom_untouched");
    tick();

    // Nominal write in IDLE exercising every field
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 32'hA5D2_70C5;
    expect_val(1, S_PROP, 32'h45, "nom_wr_prop");
    expect_val(1, S_PS1, 32'h21, "nom_wr_ps1");
    expect_val(1, S_PS2, 32'h13, "nom_wr_ps2");
    expect_val(1, S_BRP, 32'h3A, "nom_wr_brp");
    expect_val(1, S_SJW, 9, "nom_wr_sjw");
    expect_val(1, S_TS, 1, "nom_wr_ts");
    tick();

    // Reset in the middle of FAST with a pending write
    enter_fast("rstfast");
    sample_point = 1'b1;
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_wdata = 32'h0000_0003;
    expect_val(1, S_PEND, SHADOW ? 32'd1 : 32'd0, "pre_rst_pending");
    tick();
    rst = 1'b1; brs_sp = 1'b1; sampled_bit = 1'b1; sample_point = 1'b1;
    expect_val(0, S_FAST, 1, "pre_rst_fast");
    expect_val(1, S_FAST, 0, "mid_rst_fast");
    expect_val(1, S_WDOG, 0, "mid_rst_wdog");
    expect_val(1, S_PEND, 0, "mid_rst_pending");
    expect_val(1, S_PROP, 1, "mid_rst_prop");
    expect_val(1, S_BRP, 0, "mid_rst_brp");
    expect_val(1, S_TS, 0, "mid_rst_ts");
    expect_val(1, S_PROP_FD, 1, "mid_rst_prop_fd");
    expect_val(1, S_PS1_FD, 2, "mid_rst_ps1_fd");
    expect_val(1, S_SJW_FD, 0, "mid_rst_sjw_fd");
    tick();
    repeat (3) tick();

    mon_en = 1'b0;
    foreach (chk_q[i]) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL %s_never_checked cyc=%0d actual=none required=0x%0h",
               chk_q[i].name, chk_q[i].cyc, chk_q[i].val);
    end
    foreach (pulse_q[i]) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL pulse_kind%0d_missing cyc=%0d actual=none required=pulse",
               pulse_q[i].kind, pulse_q[i].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
